// File: rtl/ydemux_reg_pkg.sv
// Shared defaults and select encoding for the registered 1-to-2 steering unit.
// Select polarity follows the 2:1 read mux: 1 picks A, 0 picks B.
package ydemux_reg_pkg;

    localparam int   WIDTH_DEF = 64;
    localparam int   CNT_W_DEF = 16;
    localparam logic SEL_A     = 1'b1;
    localparam logic SEL_B     = 1'b0;

    function automatic logic route_a(input logic sel);
        return sel == SEL_A;
    endfunction

endpackage

// File: rtl/ydemux_slot.sv
// One-entry valid/ready holding register with an accept counter.
// A load on the same edge as a drain keeps the slot full with the new word.
import ydemux_reg_pkg::*;

module ydemux_slot #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             free
);

    assign free = !valid || ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            count <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            count <= count + CNT_W'(1);
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ydemux_reg.sv
// Registered 1-to-2 steering unit: routes each accepted word into slot A or B.
// Each slot stalls on its own consumer only, so in_ready follows in_sel.
import ydemux_reg_pkg::*;

module ydemux_reg #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic a_free;
    logic b_free;
    logic load_a;
    logic load_b;

    assign in_ready = route_a(in_sel) ? a_free : b_free;

    // Qualify with in_valid first so an idle, undriven select cannot load.
    assign load_a = in_valid && in_ready && (in_sel == SEL_A);
    assign load_b = in_valid && in_ready && (in_sel == SEL_B);

    ydemux_slot #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_slot_a (
        .clk      (clk),
        .reset    (reset),
        .load     (load_a),
        .load_data(in_data),
        .ready    (a_ready),
        .valid    (a_valid),
        .data     (a_data),
        .count    (a_count),
        .free     (a_free)
    );

    ydemux_slot #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_slot_b (
        .clk      (clk),
        .reset    (reset),
        .load     (load_b),
        .load_data(in_data),
        .ready    (b_ready),
        .valid    (b_valid),
        .data     (b_data),
        .count    (b_count),
        .free     (b_free)
    );

endmodule

// File: tb/tb_ydemux_reg.sv
// Bench for ydemux_reg: queue-based reference model compared every cycle,
// plus directed literal checks and a randomized phase.
module tb_ydemux_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_sel;
    logic        a_valid;
    logic        a_ready;
    logic [63:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [63:0] b_data;
    logic [15:0] a_count;
    logic [15:0] b_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] qa[$];
    logic [63:0] qb[$];
    int unsigned na = 0;
    int unsigned nb = 0;

    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_sel = 1'b0;
    logic [63:0] prev_data = '0;
    logic        m_ready;
    logic        stall;

    ydemux_reg dut (
        .clk     (clk),
        .reset   (reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .in_sel  (in_sel),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_data  (b_data),
        .a_count (a_count),
        .b_count (b_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic exp_in_ready();
        if (in_sel)
            return qa.size() == 0 || a_ready;
        return qb.size() == 0 || b_ready;
    endfunction

    // Reference model: each output is a FIFO of depth one.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            qa.delete();
            qb.delete();
            na = 0;
            nb = 0;
            prev_stall = 1'b0;
        end else begin
            if (mon_en && prev_stall) begin
                checks++;
                if (in_sel !== prev_sel || in_data !== prev_data || !in_valid) begin
                    errors++;
                    $display("FAIL producer_hold: sel %b data %h expected sel %b data %h",
                             in_sel, in_data, prev_sel, prev_data);
                end
            end
            m_ready = exp_in_ready();
            prev_stall = in_valid && !m_ready;
            prev_sel = in_sel;
            prev_data = in_data;
            if (qa.size() != 0 && a_ready) void'(qa.pop_front());
            if (qb.size() != 0 && b_ready) void'(qb.pop_front());
            if (in_valid && m_ready) begin
                if (in_sel) begin
                    qa.push_back(in_data);
                    na++;
                end else begin
                    qb.push_back(in_data);
                    nb++;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("a_valid", 64'(a_valid), 64'(qa.size() != 0));
            check("b_valid", 64'(b_valid), 64'(qb.size() != 0));
            if (qa.size() != 0) check("a_data", a_data, qa[0]);
            if (qb.size() != 0) check("b_data", b_data, qb[0]);
            check("in_ready", 64'(in_ready), 64'(exp_in_ready()));
            check("a_count", 64'(a_count), 64'(na % 65536));
            check("b_count", 64'(b_count), 64'(nb % 65536));
        end
    end

    task automatic cyc(input logic v, input logic s, input logic [63:0] d,
                       input logic ar, input logic br);
        @(posedge clk);
        #1;
        in_valid = v;
        in_sel = s;
        in_data = d;
        a_ready = ar;
        b_ready = br;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_sel = 1'b0;
        in_data = '0;
        a_ready = 1'b0;
        b_ready = 1'b0;

        @(negedge clk);
        check("rst_a_valid", 64'(a_valid), 64'd0);
        check("rst_b_valid", 64'(b_valid), 64'd0);
        check("rst_a_data", a_data, 64'd0);
        check("rst_b_data", b_data, 64'd0);
        check("rst_a_count", 64'(a_count), 64'd0);
        check("rst_b_count", 64'(b_count), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single route to A.
        cyc(1, 1, 64'h0123456789ABCDEF, 1, 1);
        check("route_in_ready", 64'(in_ready), 64'd1);
        cyc(0, 1, 64'd0, 1, 1);
        check("route_a_valid", 64'(a_valid), 64'd1);
        check("route_a_data", a_data, 64'h0123456789ABCDEF);
        check("route_b_valid", 64'(b_valid), 64'd0);
        check("route_a_count", 64'(a_count), 64'd1);
        check("route_b_count", 64'(b_count), 64'd0);

        // Back-pressure on A; B still flows.
        cyc(1, 1, 64'hAAAA, 0, 0);
        cyc(1, 1, 64'hDEAD, 0, 0);
        check("bp_in_ready_a", 64'(in_ready), 64'd0);
        check("bp_a_data", a_data, 64'hAAAA);
        cyc(1, 0, 64'hBEEF, 0, 0);
        check("bp_in_ready_b", 64'(in_ready), 64'd1);
        cyc(0, 0, 64'd0, 0, 0);
        check("bp_b_valid", 64'(b_valid), 64'd1);
        check("bp_b_data", b_data, 64'hBEEF);
        check("bp_a_held", a_data, 64'hAAAA);
        check("bp_a_count", 64'(a_count), 64'd2);
        check("bp_b_count", 64'(b_count), 64'd1);

        // Asynchronous reset between edges with both slots full.
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_a_valid", 64'(a_valid), 64'd0);
        check("arst_b_valid", 64'(b_valid), 64'd0);
        check("arst_a_count", 64'(a_count), 64'd0);
        check("arst_b_count", 64'(b_count), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Full throughput into A.
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 1, 64'(i), 1, 0);
            check("thr_in_ready", 64'(in_ready), 64'd1);
            if (i > 1) check("thr_a_data", a_data, 64'(i - 1));
        end
        cyc(0, 1, 64'd0, 1, 0);
        check("thr_a_last", a_data, 64'd8);
        check("thr_a_count", 64'(a_count), 64'd8);

        // Counter wrap on B.
        for (int i = 0; i < 65535; i++) cyc(1, 0, 64'(i), 1, 1);
        cyc(0, 0, 64'd0, 1, 1);
        check("wrap_pre", 64'(b_count), 64'hFFFF);
        cyc(1, 0, 64'h5555, 1, 1);
        cyc(0, 0, 64'd0, 1, 1);
        check("wrap_b_count", 64'(b_count), 64'h0000);
        check("wrap_a_count", 64'(a_count), 64'd8);

        // Random traffic with a lawful producer.
        mon_en = 1'b1;
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            stall = in_valid && !in_ready;
            @(posedge clk);
            #1;
            if (!stall) begin
                in_valid = $urandom_range(0, 3) != 0;
                in_sel = 1'($urandom % 2);
                in_data = {$urandom, $urandom};
            end
            a_ready = $urandom_range(0, 2) != 0;
            b_ready = $urandom_range(0, 2) != 0;
        end
        @(negedge clk);
        stall = in_valid && !in_ready;
        if (!stall) in_valid = 1'b0;
        mon_en = 1'b0;
        cyc(0, 0, 64'd0, 1, 1);
        cyc(0, 0, 64'd0, 1, 1);
        cyc(0, 0, 64'd0, 1, 1);
        check("end_a_empty", 64'(a_valid), 64'd0);
        check("end_b_empty", 64'(b_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ydemux_reg.md
Name: ydemux_reg

Overview:
- Registered 1-to-2 steering unit: the write-side counterpart of the 64-bit 2:1 select mux (yMuxx).
- Accepts one WIDTH-bit word per handshake and routes it to output A or output B by a select bit.
- Select polarity matches yMuxx: sel=1 -> A, sel=0 -> B.
- Each output owns a one-entry holding slot with valid/ready, so the two consumers stall independently.
- Per-output accept counters support bring-up and random-stimulus self-checking benches.

Parameters:
- WIDTH, 64, data width of the input and both outputs.
- CNT_W, 16, width of each per-output accept counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  unit accepts the word this cycle.
- in_data  in  WIDTH  word to route.
- in_sel  in  1  1 = route to A, 0 = route to B.
- a_valid  out  1  slot A holds a word.
- a_ready  in  1  consumer A takes the word.
- a_data  out  WIDTH  slot A word.
- b_valid  out  1  slot B holds a word.
- b_ready  in  1  consumer B takes the word.
- b_data  out  WIDTH  slot B word.
- a_count  out  CNT_W  words accepted into A since reset.
- b_count  out  CNT_W  words accepted into B since reset.

Behaviour:
- Reset (async assert, sync-release usage assumed by system):
  - a_valid=0, b_valid=0.
  - a_data=0, b_data=0.
  - a_count=0, b_count=0.
- in_ready is combinational from in_sel and slot state only:
  - sel=1: in_ready = !a_valid || a_ready.
  - sel=0: in_ready = !b_valid || b_ready.
  - in_ready never depends on in_valid.
- Accept (in_valid && in_ready) on edge N:
  - Selected slot loads in_data and is valid from N+1. Latency is one cycle.
  - The unselected slot is untouched.
- Drain: x_valid && x_ready clears x_valid at the edge, unless the same edge refills that slot.
- Simultaneous drain and refill of the same slot: slot stays valid and takes the new word, giving full throughput of one word per cycle per slot.
- A full slot with x_ready=0 holds x_data stable and keeps x_valid high.
- Producer rule: in_sel and in_data must be held while in_valid=1 and in_ready=0. A violation is flagged by the bench, not the RTL.
- The unselected slot's stall never blocks traffic to the other slot. in_ready may toggle cycle-to-cycle as in_sel changes.
- Counters:
  - Increment by 1 on each accept to their slot, not on drain.
  - Wrap modulo 2^CNT_W, e.g. 0xFFFF -> 0x0000, with no saturation and no flag.
- Reset mid-operation: pending slot contents are discarded immediately (valid=0). No partial word is ever presented.
- X on in_sel while in_valid=0 must not affect state.

Decomposition:
- Shared package/include (ydemux_defs.v):
  - WIDTH default 64.
  - CNT_W default 16.
  - SEL_A=1'b1, SEL_B=1'b0.
- Sub-module ydemux_slot:
  - One-entry valid/ready holding register with load, drain and counter.
  - Instantiated twice; the top holds only select decode and in_ready.

Test Plan:
- Reset then single routes: sel=1, data=0x0123456789ABCDEF, a_ready=1 -> a_valid=1 next cycle with that data; b_valid stays 0; a_count=1, b_count=0.
- Back-pressure: fill A with a_ready=0, then present sel=1 data=0xDEAD -> in_ready=0, a_data unchanged. Present sel=0 data=0xBEEF in the same stall -> accepted to B in one cycle.
- Full throughput: 8 consecutive sel=1 words 1..8 with a_ready=1 -> A emits 1..8 on consecutive cycles; a_count=8.
- Counter wrap: preload 65535 accepts to B -> next accept gives b_count=0x0000; a_count unaffected.
- Async reset mid-stall: both slots full and held, assert reset between edges -> a_valid=b_valid=0 and counts=0 immediately, before the next edge.
- Random (15+ iterations, $random data, sel=$random%2, random readies) -> scoreboard per output: order and data match exactly; display pass/fail per word.
